// File: rtl/multicycle_ctrl_if.sv
// Control bundle between the decoder/data-memory side (master) and multicycle_ctrl (slave).
interface multicycle_ctrl_if #(
    parameter int WB_SEL_W = 2,
    parameter int CNT_W    = 32
);
    logic [WB_SEL_W+4:0] alusel;
    logic                stall;
    logic                mem_ready;
    logic                pc_en;
    logic                id_en;
    logic                ex_en;
    logic                mem_en;
    logic                wb_en;
    logic                jump_en;
    logic                imm_en;
    logic                expc_en;
    logic                l_or_s;
    logic [WB_SEL_W-1:0] wb_ctrl;
    logic                err;
    logic [CNT_W-1:0]    instr_retired;
    logic [CNT_W-1:0]    mem_stall_cycles;

    modport master (
        output alusel, stall, mem_ready,
        input  pc_en, id_en, ex_en, mem_en, wb_en,
        input  jump_en, imm_en, expc_en, l_or_s, wb_ctrl, err,
        input  instr_retired, mem_stall_cycles
    );

    modport slave (
        input  alusel, stall, mem_ready,
        output pc_en, id_en, ex_en, mem_en, wb_en,
        output jump_en, imm_en, expc_en, l_or_s, wb_ctrl, err,
        output instr_retired, mem_stall_cycles
    );
endinterface

// File: rtl/multicycle_ctrl.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer with memory wait timeout and fetch stall.
// Define MC_CTRL_PERF_EN to build the instr_retired / mem_stall_cycles counters.
module multicycle_ctrl #(
    parameter int WB_SEL_W = 2,
    parameter int MAX_WAIT = 15,
    parameter int CNT_W    = 32
) (
    input  logic             clk,
    input  logic             rst,
    multicycle_ctrl_if.slave bus
);
    localparam int MEM_BIT = WB_SEL_W + 1;
    localparam int ST_BIT  = WB_SEL_W + 2;
    localparam int IMM_BIT = WB_SEL_W + 3;
    localparam int JMP_BIT = WB_SEL_W + 4;
    localparam int WAIT_W  = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;
    localparam logic [WAIT_W-1:0] WAIT_MAX  = WAIT_W'(MAX_WAIT);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MAX_WAIT - 1);

    typedef enum logic [2:0] {
        S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_ERR
    } state_t;

    state_t              state;
    state_t              next_state;
    logic [WAIT_W-1:0]   wait_cnt;
    logic [WB_SEL_W-1:0] wb_sel;
    logic                mem_wait;
    logic                timeout;
    logic                jump_q, imm_q, expc_q, ls_q, err_q;
    logic [WB_SEL_W-1:0] wb_q;

    assign wb_sel   = bus.alusel[WB_SEL_W:1];
    assign mem_wait = (state == S_MEM) && !bus.mem_ready;
    // Timeout fires on the wait cycle that would bring the counter to MAX_WAIT.
    assign timeout  = (MAX_WAIT > 0) && mem_wait && (wait_cnt == WAIT_LAST);

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_FETCH;
        else     state <= next_state;
    end

    // NOTE: every output of a combinational block is defaulted first; a missed branch would infer a latch.
    always_comb begin
        next_state = state;
        case (state)
            S_FETCH:  next_state = bus.stall ? S_FETCH : S_DECODE;
            S_DECODE: next_state = S_EXEC;
            S_EXEC: begin
                if (!bus.alusel[0])           next_state = S_FETCH;
                else if (bus.alusel[MEM_BIT]) next_state = S_MEM;
                else                          next_state = S_WB;
            end
            S_MEM: begin
                if (bus.mem_ready) next_state = bus.alusel[ST_BIT] ? S_FETCH : S_WB;
                else if (timeout)  next_state = S_ERR;
            end
            S_WB:    next_state = S_FETCH;
            default: next_state = S_ERR;
        endcase
    end

    // Enables are forced low while rst is held, even though the state already reads FETCH.
    always_comb begin
        bus.pc_en  = 1'b0;
        bus.id_en  = 1'b0;
        bus.ex_en  = 1'b0;
        bus.mem_en = 1'b0;
        bus.wb_en  = 1'b0;
        if (!rst) begin
            case (state)
                S_FETCH:  bus.pc_en  = 1'b1;
                S_DECODE: bus.id_en  = 1'b1;
                S_EXEC:   bus.ex_en  = 1'b1;
                S_MEM:    bus.mem_en = 1'b1;
                S_WB:     bus.wb_en  = 1'b1;
                default:  ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)                                         wait_cnt <= '0;
        else if (state == S_EXEC && next_state == S_MEM) wait_cnt <= '0;
        else if (mem_wait && wait_cnt != WAIT_MAX)       wait_cnt <= wait_cnt + WAIT_W'(1);
    end

    // Sideband fields latch on the edge that enters their stage and hold otherwise.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            jump_q <= 1'b0;
            imm_q  <= 1'b0;
            expc_q <= 1'b0;
            ls_q   <= 1'b0;
            wb_q   <= '0;
            err_q  <= 1'b0;
        end else begin
            if (next_state == S_FETCH && state != S_FETCH) jump_q <= bus.alusel[JMP_BIT];
            if (next_state == S_EXEC && state != S_EXEC) begin
                imm_q  <= bus.alusel[IMM_BIT];
                expc_q <= &wb_sel;
            end
            if (next_state == S_MEM && state != S_MEM) ls_q <= bus.alusel[ST_BIT];
            if (next_state == S_WB && state != S_WB)   wb_q <= wb_sel;
            if (next_state == S_ERR)                   err_q <= 1'b1;
        end
    end

    assign bus.jump_en = jump_q;
    assign bus.imm_en  = imm_q;
    assign bus.expc_en = expc_q;
    assign bus.l_or_s  = ls_q;
    assign bus.wb_ctrl = wb_q;
    assign bus.err     = err_q;

`ifdef MC_CTRL_PERF_EN
    logic [CNT_W-1:0] retired_q;
    logic [CNT_W-1:0] stall_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            retired_q <= '0;
            stall_q   <= '0;
        end else begin
            if (next_state == S_FETCH && state != S_FETCH) retired_q <= retired_q + CNT_W'(1);
            if (mem_wait)                                  stall_q   <= stall_q + CNT_W'(1);
        end
    end

    assign bus.instr_retired    = retired_q;
    assign bus.mem_stall_cycles = stall_q;
`else
    assign bus.instr_retired    = {CNT_W{1'b0}};
    assign bus.mem_stall_cycles = {CNT_W{1'b0}};
`endif
endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: directed stage sequences plus randomized traffic
// compared every cycle against a stage-level behavioural model.
module tb_multicycle_ctrl;
    localparam int WB_SEL_W = 2;
    localparam int MAX_WAIT = 15;
    localparam int CNT_W    = 32;
    localparam int AW       = WB_SEL_W + 5;
    localparam int F = 0, D = 1, E = 2, M = 3, W = 4, X = 5;
`ifdef MC_CTRL_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;

    multicycle_ctrl_if #(.WB_SEL_W(WB_SEL_W), .CNT_W(CNT_W)) bus ();

    multicycle_ctrl #(.WB_SEL_W(WB_SEL_W), .MAX_WAIT(MAX_WAIT), .CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s at %0t: got 0x%0h, want 0x%0h", name, $time, act, exp);
    endtask

    function automatic logic [4:0] en_vec();
        return {bus.wb_en, bus.mem_en, bus.ex_en, bus.id_en, bus.pc_en};
    endfunction

    function automatic logic [4:0] stage_en(input int s);
        return (s >= F && s <= W) ? 5'(1 << s) : 5'b0;
    endfunction

    function automatic logic [4:0] en_of(input byte c);
        case (c)
            "F":     return 5'b00001;
            "D":     return 5'b00010;
            "E":     return 5'b00100;
            "M":     return 5'b01000;
            "W":     return 5'b10000;
            default: return 5'b00000;
        endcase
    endfunction

    // Behavioural model: the stage an instruction is in, plus the values each sideband must hold.
    int                  m_stage = F;
    int                  m_nxt;
    int                  m_waits = 0;
    logic                m_jump = 1'b0, m_imm = 1'b0, m_expc = 1'b0, m_ls = 1'b0, m_err = 1'b0;
    logic [WB_SEL_W-1:0] m_wb  = '0;
    logic [CNT_W-1:0]    m_ret = '0;
    logic [CNT_W-1:0]    m_stl = '0;

    always_comb begin
        m_nxt = m_stage;
        case (m_stage)
            F: m_nxt = bus.stall ? F : D;
            D: m_nxt = E;
            E: m_nxt = !bus.alusel[0] ? F : (bus.alusel[WB_SEL_W+1] ? M : W);
            M: begin
                if (bus.mem_ready)                                  m_nxt = bus.alusel[WB_SEL_W+2] ? F : W;
                else if (MAX_WAIT > 0 && m_waits + 1 >= MAX_WAIT)   m_nxt = X;
            end
            W: m_nxt = F;
            default: m_nxt = X;
        endcase
    end

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_stage <= F;
            m_waits <= 0;
            m_jump  <= 1'b0;
            m_imm   <= 1'b0;
            m_expc  <= 1'b0;
            m_ls    <= 1'b0;
            m_err   <= 1'b0;
            m_wb    <= '0;
            m_ret   <= '0;
            m_stl   <= '0;
        end else begin
            if (m_stage == M && !bus.mem_ready) begin
                m_stl <= m_stl + 1;
                if (m_waits < MAX_WAIT) m_waits <= m_waits + 1;
            end
            if (m_nxt == E && m_stage != E) begin
                m_imm  <= bus.alusel[WB_SEL_W+3];
                m_expc <= (bus.alusel[WB_SEL_W:1] == {WB_SEL_W{1'b1}});
            end
            if (m_nxt == M && m_stage != M) begin
                m_ls    <= bus.alusel[WB_SEL_W+2];
                m_waits <= 0;
            end
            if (m_nxt == W && m_stage != W) m_wb <= bus.alusel[WB_SEL_W:1];
            if (m_nxt == F && (m_stage == E || m_stage == M || m_stage == W)) begin
                m_ret  <= m_ret + 1;
                m_jump <= bus.alusel[WB_SEL_W+4];
            end
            if (m_nxt == X) m_err <= 1'b1;
            m_stage <= m_nxt;
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            check("model_en", en_vec(), rst ? 5'b0 : stage_en(m_stage));
            check("model_side", {bus.jump_en, bus.imm_en, bus.expc_en, bus.l_or_s, bus.wb_ctrl},
                  {m_jump, m_imm, m_expc, m_ls, m_wb});
            check("model_err", bus.err, m_err);
            check("model_retired", bus.instr_retired, PERF ? m_ret : {CNT_W{1'b0}});
            check("model_stalls", bus.mem_stall_cycles, PERF ? m_stl : {CNT_W{1'b0}});
        end
    end

    // Leaves the bench just after reset release, inside the first FETCH cycle.
    task automatic do_reset();
        @(negedge clk);
        #2 rst = 1'b1;
        bus.stall     = 1'b0;
        bus.mem_ready = 1'b1;
        @(negedge clk);
        #2 rst = 1'b0;
        #1;
    endtask

    // seq[i] is the stage expected in cycle i; rdy[i] is mem_ready driven for the edge ending cycle i.
    task automatic run_seq(input string name, input string seq, input string rdy);
        for (int i = 0; i < seq.len(); i++) begin
            if (i > 0) @(negedge clk);
            check(name, en_vec(), en_of(seq[i]));
            bus.mem_ready = (rdy[i] == "1");
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        string s, r;
        int    bias;
        bus.alusel    = '0;
        bus.stall     = 1'b0;
        bus.mem_ready = 1'b1;

        repeat (2) @(negedge clk);
        check("reset_en", en_vec(), 5'b0);
        check("reset_err", bus.err, 1'b0);
        #2 rst = 1'b0;
        #1 check("release_pc_en", en_vec(), 5'b00001);

        // ALU op: wr=1, mem=0, wb sel=01
        do_reset();
        bus.alusel = 7'b0000011;
        run_seq("alu_seq", "FDEW", "1111");
        check("alu_wb_ctrl", bus.wb_ctrl, 2'b01);
        @(negedge clk);
        check("alu_back_fetch", en_vec(), 5'b00001);

        // Load with mem_ready low for three MEM cycles
        do_reset();
        bus.alusel = 7'b0001101;
        run_seq("load_seq", "FDEMMMMWF", "111000111");
        check("load_stalls", bus.mem_stall_cycles, PERF ? 3 : 0);
        check("load_retired", bus.instr_retired, PERF ? 1 : 0);
        check("load_wb_ctrl_ls", {bus.wb_ctrl, bus.l_or_s}, 3'b100);

        // Store with wb sel=11: no WB stage
        do_reset();
        bus.alusel = 7'b0011111;
        run_seq("store_seq", "FDEM", "1111");
        check("store_expc_ls", {bus.expc_en, bus.l_or_s}, 2'b11);
        @(negedge clk);
        check("store_no_wb", en_vec(), 5'b00001);

        // Timeout: fifteen wait cycles then ERR
        do_reset();
        bus.alusel = 7'b0001101;
        s = "FDE";
        r = "111";
        for (int i = 0; i < 15; i++) s = {s, "M"};
        s = {s, "XXXX"};
        for (int i = 0; i < 19; i++) r = {r, "0"};
        run_seq("timeout_seq", s, r);
        check("timeout_err", bus.err, 1'b1);
        check("timeout_stalls", bus.mem_stall_cycles, PERF ? 15 : 0);
        do_reset();
        check("err_cleared", bus.err, 1'b0);

        // mem_ready on the fifteenth MEM cycle wins over the timeout
        bus.alusel = 7'b0001101;
        s = "FDE";
        r = "111";
        for (int i = 0; i < 15; i++) s = {s, "M"};
        s = {s, "WF"};
        for (int i = 0; i < 14; i++) r = {r, "0"};
        r = {r, "111"};
        run_seq("ready_wins_seq", s, r);
        check("ready_wins_err", bus.err, 1'b0);

        // No-write jump instruction, then a five-cycle fetch stall
        do_reset();
        bus.alusel = 7'b1000000;
        run_seq("nowrite_seq", "FDEF", "1111");
        check("nowrite_jump", bus.jump_en, 1'b1);
        bus.alusel = '0;
        bus.stall  = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("stall_hold", en_vec(), 5'b00001);
        end
        bus.stall = 1'b0;
        check("stall_retired", bus.instr_retired, PERF ? 1 : 0);
        check("stall_jump_held", bus.jump_en, 1'b1);
        @(negedge clk);
        check("stall_release", en_vec(), 5'b00010);

        // Reset asserted during EXEC
        do_reset();
        bus.alusel = 7'b0000011;
        run_seq("rst_warm", "FDEWF", "11111");
        bus.alusel = 7'b0100110;
        @(negedge clk);
        run_seq("rst_pre", "DE", "11");
        check("rst_pre_side", {bus.imm_en, bus.expc_en}, 2'b11);
        check("rst_pre_retired", bus.instr_retired, PERF ? 1 : 0);
        #2 rst = 1'b1;
        #1;
        check("rst_async_en", en_vec(), 5'b0);
        check("rst_async_side", {bus.jump_en, bus.imm_en, bus.expc_en, bus.l_or_s, bus.wb_ctrl, bus.err}, 7'b0);
        check("rst_async_cnt", {bus.instr_retired, bus.mem_stall_cycles}, 64'd0);
        @(negedge clk);
        #2 rst = 1'b0;
        #1;
        check("rst_release_pc", en_vec(), 5'b00001);
        check("rst_release_cnt", {bus.instr_retired, bus.mem_stall_cycles}, 64'd0);

        // Randomized traffic with changing memory latency profiles
        do_reset();
        bias = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(negedge clk);
            if (cyc % 64 == 0) bias = $urandom_range(2, 0);
            bus.alusel = AW'($urandom);
            bus.stall  = ($urandom_range(3, 0) == 0);
            case (bias)
                0:       bus.mem_ready = ($urandom_range(9, 0) != 0);
                1:       bus.mem_ready = ($urandom_range(1, 0) != 0);
                default: bus.mem_ready = ($urandom_range(19, 0) == 0);
            endcase
            if ((m_stage == X && $urandom_range(3, 0) == 0) || $urandom_range(299, 0) == 0) begin
                #2 rst = 1'b1;
                @(negedge clk);
                #2 rst = 1'b0;
            end
        end

        repeat (2) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
